// File: rtl/mprj_checkpoint_monitor.sv
// Purpose: watches a firmware checkpoint bus for an ordered run of NUM_CHK codes; flags pass, fail or timeout.
// Latency: all flags are registered one edge after the deciding sample; a code must hold STABLE_CYC samples to be accepted.
// Backpressure: none; a passive observer that never stalls the bus it watches.
module mprj_checkpoint_monitor #(
  parameter int unsigned        CODE_W      = 16,
  parameter logic [CODE_W-1:0]  BASE        = CODE_W'(16'hAB60),
  parameter logic [CODE_W-1:0]  STEP        = CODE_W'(1),
  parameter int unsigned        NUM_CHK     = 2,
  parameter logic [CODE_W-1:0]  TAG_MASK    = CODE_W'(16'hFFF0),
  parameter int unsigned        STABLE_CYC  = 4,
  parameter int unsigned        TIMEOUT_CYC = 70000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              arm_i,
  input  logic [CODE_W-1:0] code_i,
  output logic              busy_o,
  output logic              pass_o,
  output logic              fail_o,
  output logic              timeout_o,
  output logic [7:0]        stage_o,
  output logic [31:0]       stamp_o
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_QUAL, S_PASS, S_FAIL} state_t;

  localparam logic [31:0] STB_LAST = 32'(STABLE_CYC);
  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYC - 1);
  localparam logic [7:0]  NUM_LAST = 8'(NUM_CHK);

  state_t              state_q, state_d;
  logic [CODE_W-1:0]   exp_q, exp_d;
  logic [7:0]          stage_q, stage_d;
  logic [31:0]         stamp_q, stamp_d;
  logic [31:0]         timer_q, timer_d;
  logic [31:0]         cnt_q, cnt_d;
  logic                pass_q, pass_d;
  logic                fail_q, fail_d;
  logic                to_q, to_d;

  logic                running;
  logic                chk_like;
  logic                match;
  logic                prev_hit;
  logic                accept;
  logic [31:0]         cnt_inc;
  logic [31:0]         timer_inc;
  logic [7:0]          stage_inc;
  logic [CODE_W-1:0]   prev_code;

  // The expected code is tracked incrementally, so the last accepted code is
  // simply one STEP behind it; holding that code on the bus is never an error.
  assign running   = (state_q == S_WAIT) || (state_q == S_QUAL);
  assign chk_like  = (code_i & TAG_MASK) == (BASE & TAG_MASK);
  assign match     = (code_i == exp_q);
  assign prev_code = exp_q - STEP;
  assign prev_hit  = (stage_q != 8'd0) && (code_i == prev_code);
  assign cnt_inc   = (state_q == S_QUAL) ? cnt_q + 32'd1 : 32'd1;
  assign accept    = running && match && (cnt_inc == STB_LAST);
  assign timer_inc = (timer_q == 32'hFFFF_FFFF) ? timer_q : timer_q + 32'd1;
  assign stage_inc = stage_q + 8'd1;

  // Next-state and next-flag logic; priority is arm > accept > timeout > mismatch.
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    stage_d = stage_q;
    stamp_d = stamp_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    to_d    = to_q;
    if (arm_i) begin
      state_d = S_WAIT;
      exp_d   = BASE;
      stage_d = 8'd0;
      stamp_d = 32'd0;
      timer_d = 32'd0;
      cnt_d   = 32'd0;
      pass_d  = 1'b0;
      fail_d  = 1'b0;
      to_d    = 1'b0;
    end else if (running) begin
      timer_d = timer_inc;
      if (match) begin
        cnt_d   = cnt_inc;
        state_d = S_QUAL;
      end
      if (accept) begin
        stage_d = stage_inc;
        stamp_d = timer_q;
        exp_d   = exp_q + STEP;
        cnt_d   = 32'd0;
        if (stage_inc == NUM_LAST) begin
          state_d = S_PASS;
          pass_d  = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end else if (timer_q == TO_LAST) begin
        state_d = S_FAIL;
        fail_d  = 1'b1;
        to_d    = 1'b1;
      end else if (!match) begin
        cnt_d = 32'd0;
        if (state_q == S_QUAL) begin
          // A broken qualifying run is a bus glitch, not an ordering error.
          state_d = S_WAIT;
        end else if (chk_like && !prev_hit) begin
          state_d = S_FAIL;
          fail_d  = 1'b1;
        end
      end
    end
  end

  // State and flag registers with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      exp_q   <= BASE;
      stage_q <= 8'd0;
      stamp_q <= 32'd0;
      timer_q <= 32'd0;
      cnt_q   <= 32'd0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      stage_q <= stage_d;
      stamp_q <= stamp_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      to_q    <= to_d;
    end
  end

  assign busy_o    = running;
  assign pass_o    = pass_q;
  assign fail_o    = fail_q;
  assign timeout_o = to_q;
  assign stage_o   = stage_q;
  assign stamp_o   = stamp_q;

endmodule

// File: tb/tb_mprj_checkpoint_monitor.sv
// Purpose: directed vector bench for mprj_checkpoint_monitor across four parameter sets.
// Latency: inputs driven after the falling edge, outputs sampled on the following falling edges.
// Backpressure: not applicable; stimulus is free-running.
module tb_mprj_checkpoint_monitor;

  typedef struct packed {
    logic        busy;
    logic        pass;
    logic        fail;
    logic        to;
    logic [7:0]  stage;
    logic [31:0] stamp;
  } obs_t;

  typedef struct {
    string       name;
    logic        arm;
    logic [15:0] code;
    int          reps;
    obs_t        exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, w_rst;

  logic d_arm, t_arm, b_arm, w_arm;
  logic [15:0] d_code, t_code, b_code, w_code;
  logic d_busy, d_pass, d_fail, d_to;
  logic t_busy, t_pass, t_fail, t_to;
  logic b_busy, b_pass, b_fail, b_to;
  logic w_busy, w_pass, w_fail, w_to;
  logic [7:0]  d_stage, t_stage, b_stage, w_stage;
  logic [31:0] d_stamp, t_stamp, b_stamp, w_stamp;
  obs_t d_act, t_act, b_act, w_act;

  assign d_act = {d_busy, d_pass, d_fail, d_to, d_stage, d_stamp};
  assign t_act = {t_busy, t_pass, t_fail, t_to, t_stage, t_stamp};
  assign b_act = {b_busy, b_pass, b_fail, b_to, b_stage, b_stamp};
  assign w_act = {w_busy, w_pass, w_fail, w_to, w_stage, w_stamp};

  // Default parameters.
  mprj_checkpoint_monitor u_def (
    .wb_clk_i(clk), .wb_rst_i(rst), .arm_i(d_arm), .code_i(d_code),
    .busy_o(d_busy), .pass_o(d_pass), .fail_o(d_fail), .timeout_o(d_to),
    .stage_o(d_stage), .stamp_o(d_stamp)
  );

  // Short timeout budget.
  mprj_checkpoint_monitor #(.TIMEOUT_CYC(100)) u_to (
    .wb_clk_i(clk), .wb_rst_i(rst), .arm_i(t_arm), .code_i(t_code),
    .busy_o(t_busy), .pass_o(t_pass), .fail_o(t_fail), .timeout_o(t_to),
    .stage_o(t_stage), .stamp_o(t_stamp)
  );

  // Single checkpoint racing a tight budget.
  mprj_checkpoint_monitor #(.TIMEOUT_CYC(20), .STABLE_CYC(4), .NUM_CHK(1)) u_bd (
    .wb_clk_i(clk), .wb_rst_i(rst), .arm_i(b_arm), .code_i(b_code),
    .busy_o(b_busy), .pass_o(b_pass), .fail_o(b_fail), .timeout_o(b_to),
    .stage_o(b_stage), .stamp_o(b_stamp)
  );

  // Expected codes wrapping through zero, every value checkpoint-like.
  mprj_checkpoint_monitor #(.BASE(16'hFFFF), .STEP(16'h0001), .NUM_CHK(2), .TAG_MASK(16'h0000)) u_wr (
    .wb_clk_i(clk), .wb_rst_i(w_rst), .arm_i(w_arm), .code_i(w_code),
    .busy_o(w_busy), .pass_o(w_pass), .fail_o(w_fail), .timeout_o(w_to),
    .stage_o(w_stage), .stamp_o(w_stamp)
  );

  int n_vec = 0;
  int n_bad = 0;
  vec_t vecs[$];

  function automatic obs_t o(logic b, logic p, logic f, logic t, logic [7:0] s, logic [31:0] sp);
    obs_t r;
    r.busy  = b;
    r.pass  = p;
    r.fail  = f;
    r.to    = t;
    r.stage = s;
    r.stamp = sp;
    return r;
  endfunction

  function automatic void add(string n, logic a, logic [15:0] c, int r, obs_t e);
    vec_t v;
    v.name = n;
    v.arm  = a;
    v.code = c;
    v.reps = r;
    v.exp  = e;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got busy=%b pass=%b fail=%b to=%b stage=%0d stamp=%0d, want busy=%b pass=%b fail=%b to=%b stage=%0d stamp=%0d",
               name, act.busy, act.pass, act.fail, act.to, act.stage, act.stamp,
               exp.busy, exp.pass, exp.fail, exp.to, exp.stage, exp.stamp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    // Default-parameter scenarios; arm edge is cycle 0, stamp is the timer
    // value at the accepting sample (timer reads k-1 at the k-th edge after arm).
    add("arm_main",    1'b1, 16'h0000,  1, o(1,0,0,0,8'd0,32'd0));
    add("zeros",       1'b0, 16'h0000, 10, o(1,0,0,0,8'd0,32'd0));
    add("ab60_qual",   1'b0, 16'hAB60,  3, o(1,0,0,0,8'd0,32'd0));
    add("ab60_accept", 1'b0, 16'hAB60,  1, o(1,0,0,0,8'd1,32'd13));
    add("ab60_hold",   1'b0, 16'hAB60,  6, o(1,0,0,0,8'd1,32'd13));
    add("ab61_qual",   1'b0, 16'hAB61,  3, o(1,0,0,0,8'd1,32'd13));
    add("ab61_pass",   1'b0, 16'hAB61,  1, o(0,1,0,0,8'd2,32'd23));
    add("pass_sticky", 1'b0, 16'hAB61,  6, o(0,1,0,0,8'd2,32'd23));
    add("arm_glitch",  1'b1, 16'h0000,  1, o(1,0,0,0,8'd0,32'd0));
    add("glitch_run",  1'b0, 16'hAB60,  2, o(1,0,0,0,8'd0,32'd0));
    add("glitch_gap",  1'b0, 16'h0000,  1, o(1,0,0,0,8'd0,32'd0));
    add("glitch_qual", 1'b0, 16'hAB60,  3, o(1,0,0,0,8'd0,32'd0));
    add("glitch_acc",  1'b0, 16'hAB60,  1, o(1,0,0,0,8'd1,32'd6));
    add("prev_hold",   1'b0, 16'hAB60,  3, o(1,0,0,0,8'd1,32'd6));
    add("bad_code",    1'b0, 16'hAB65,  1, o(0,0,1,0,8'd1,32'd6));
    add("arm_ooo",     1'b1, 16'h0000,  1, o(1,0,0,0,8'd0,32'd0));
    add("out_of_order",1'b0, 16'hAB61,  1, o(0,0,1,0,8'd0,32'd0));
    add("arm_rst",     1'b1, 16'h0000,  1, o(1,0,0,0,8'd0,32'd0));
    add("pre_rearm",   1'b0, 16'hAB60,  2, o(1,0,0,0,8'd0,32'd0));
    add("rearm_busy",  1'b1, 16'hAB60,  1, o(1,0,0,0,8'd0,32'd0));
    add("rearm_qual",  1'b0, 16'hAB60,  3, o(1,0,0,0,8'd0,32'd0));
    add("rearm_acc",   1'b0, 16'hAB60,  1, o(1,0,0,0,8'd1,32'd3));

    rst = 1'b1; w_rst = 1'b1;
    d_arm = 1'b0; t_arm = 1'b0; b_arm = 1'b0; w_arm = 1'b0;
    d_code = 16'h0000; t_code = 16'h0000; b_code = 16'h0000; w_code = 16'hFFFF;
    repeat (2) @(negedge clk);
    rst = 1'b0; w_rst = 1'b0;
    @(negedge clk);
    check("reset_def", d_act, o(0,0,0,0,8'd0,32'd0));
    check("reset_to",  t_act, o(0,0,0,0,8'd0,32'd0));
    check("reset_bd",  b_act, o(0,0,0,0,8'd0,32'd0));
    check("reset_wr",  w_act, o(0,0,0,0,8'd0,32'd0));

    foreach (vecs[i]) begin
      d_arm  = vecs[i].arm;
      d_code = vecs[i].code;
      for (int k = 0; k < vecs[i].reps; k++) begin
        @(negedge clk);
        d_arm = 1'b0;
      end
      check(vecs[i].name, d_act, vecs[i].exp);
    end

    // Timeout: fail lands exactly 100 edges after the arm edge.
    t_arm = 1'b1;
    @(negedge clk);
    t_arm = 1'b0;
    repeat (99) @(negedge clk);
    check("to_before", t_act, o(1,0,0,0,8'd0,32'd0));
    @(negedge clk);
    check("to_fire", t_act, o(0,0,1,1,8'd0,32'd0));

    // Boundary: accept on the last budget sample is in time.
    b_arm = 1'b1;
    @(negedge clk);
    b_arm = 1'b0;
    repeat (16) @(negedge clk);
    b_code = 16'hAB60;
    repeat (3) @(negedge clk);
    check("bd_qual", b_act, o(1,0,0,0,8'd0,32'd0));
    @(negedge clk);
    check("bd_pass", b_act, o(0,1,0,0,8'd1,32'd19));

    // Boundary shifted one cycle later: timeout wins.
    b_code = 16'h0000;
    b_arm  = 1'b1;
    @(negedge clk);
    b_arm = 1'b0;
    repeat (17) @(negedge clk);
    b_code = 16'hAB60;
    repeat (2) @(negedge clk);
    check("bd_late_qual", b_act, o(1,0,0,0,8'd0,32'd0));
    @(negedge clk);
    check("bd_late_to", b_act, o(0,0,1,1,8'd0,32'd0));

    // Wrap: FFFF then 0000.
    w_arm = 1'b1;
    @(negedge clk);
    w_arm = 1'b0;
    repeat (4) @(negedge clk);
    check("wr_first", w_act, o(1,0,0,0,8'd1,32'd3));
    w_code = 16'h0000;
    repeat (4) @(negedge clk);
    check("wr_pass", w_act, o(0,1,0,0,8'd2,32'd7));

    // Second run, then reset mid-run clears everything on the next edge.
    w_code = 16'hFFFF;
    w_arm  = 1'b1;
    @(negedge clk);
    w_arm = 1'b0;
    repeat (4) @(negedge clk);
    check("wr_run2", w_act, o(1,0,0,0,8'd1,32'd3));
    w_rst = 1'b1;
    @(negedge clk);
    check("wr_reset", w_act, o(0,0,0,0,8'd0,32'd0));
    w_rst = 1'b0;
    @(negedge clk);
    check("wr_idle", w_act, o(0,0,0,0,8'd0,32'd0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
